// File: rtl/alu_issue_stage.sv
// Decode-and-issue stage feeding the 32-bit ALU.
// Turns a fetched MIPS instruction and its register-file operands into ALU
// control, operands and shift amount, then registers them into the ID/EX
// slot behind a valid/ready handshake. A load in EX whose destination is a
// source of the incoming instruction blocks acceptance for one cycle, which
// leaves exactly one bubble behind the load.
module alu_issue_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [3:0]  ex_alu_ctrl,
    output logic [31:0] ex_in1,
    output logic [31:0] ex_in2,
    output logic [4:0]  ex_shamt,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [31:0] ex_store_data,
    output logic        ex_illegal
);

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // ALU control codes understood by EX; zero means no operation.
    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SUB  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_LESS = 4'd8;
    localparam logic [3:0] ALU_NOR  = 4'd9;
    localparam logic [3:0] ALU_SLLV = 4'd10;
    localparam logic [3:0] ALU_SRLV = 4'd11;
    localparam logic [3:0] ALU_SRAV = 4'd12;

    // Primary opcodes.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes.
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Everything that travels from ID into EX alongside the valid bit.
    typedef struct packed {
        logic [3:0]        alu_ctrl;
        logic [DATA_W-1:0] in1;
        logic [DATA_W-1:0] in2;
        logic [REG_W-1:0]  shamt;
        logic [REG_W-1:0]  rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [DATA_W-1:0] store_data;
        logic              illegal;
    } payload_t;

    // ---------------------------------------------------------------
    // p0: instruction fields and operand preparation (combinational)
    // ---------------------------------------------------------------
    logic [5:0]               op_p0;
    logic [5:0]               funct_p0;
    logic [REG_W-1:0]         rs_p0;
    logic [REG_W-1:0]         rt_p0;
    logic [REG_W-1:0]         rd_p0;
    logic [REG_W-1:0]         sh_p0;
    logic signed [15:0]       imm_s_p0;
    logic signed [DATA_W-1:0] imm_sext_p0;
    logic [DATA_W-1:0]        imm_zext_p0;
    logic [DATA_W-1:0]        rs_shift_p0;

    assign op_p0    = id_instr[31:26];
    assign rs_p0    = id_instr[25:21];
    assign rt_p0    = id_instr[20:16];
    assign rd_p0    = id_instr[15:11];
    assign sh_p0    = id_instr[10:6];
    assign funct_p0 = id_instr[5:0];
    assign imm_s_p0 = id_instr[15:0];

    assign imm_sext_p0 = {{(DATA_W-16){imm_s_p0[15]}}, imm_s_p0};
    assign imm_zext_p0 = {{(DATA_W-16){1'b0}}, id_instr[15:0]};
    // Variable shifts only ever use the low five bits of rs.
    assign rs_shift_p0 = {{(DATA_W-REG_W){1'b0}}, id_rs_data[REG_W-1:0]};

    payload_t dec_p0;
    logic     legal_p0;
    logic     uses_rs_p0;
    logic     uses_rt_p0;
    logic     hazard_p0;
    logic     accept_p0;

    // Decode the instruction into ALU control, operands and writeback intent.
    always_comb begin
        dec_p0     = '0;
        legal_p0   = 1'b1;
        uses_rs_p0 = 1'b1;
        uses_rt_p0 = 1'b0;

        case (op_p0)
            OP_RTYPE: begin
                uses_rt_p0       = 1'b1;
                dec_p0.rd        = rd_p0;
                dec_p0.reg_write = 1'b1;
                dec_p0.in1       = id_rs_data;
                dec_p0.in2       = id_rt_data;
                case (funct_p0)
                    FN_ADD, FN_ADDU: dec_p0.alu_ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: dec_p0.alu_ctrl = ALU_SUB;
                    FN_AND:          dec_p0.alu_ctrl = ALU_AND;
                    FN_OR:           dec_p0.alu_ctrl = ALU_OR;
                    FN_NOR:          dec_p0.alu_ctrl = ALU_NOR;
                    FN_SLT:          dec_p0.alu_ctrl = ALU_LESS;
                    FN_SLL, FN_SRL, FN_SRA: begin
                        // Constant shifts: rt is shifted by the instruction's shamt.
                        uses_rs_p0   = 1'b0;
                        dec_p0.in1   = id_rt_data;
                        dec_p0.in2   = '0;
                        dec_p0.shamt = sh_p0;
                        case (funct_p0)
                            FN_SLL:  dec_p0.alu_ctrl = ALU_SLL;
                            FN_SRL:  dec_p0.alu_ctrl = ALU_SRL;
                            default: dec_p0.alu_ctrl = ALU_SRA;
                        endcase
                    end
                    FN_SLLV, FN_SRLV, FN_SRAV: begin
                        // Variable shifts: rt is shifted by rs[4:0], carried on in2.
                        dec_p0.in1 = id_rt_data;
                        dec_p0.in2 = rs_shift_p0;
                        case (funct_p0)
                            FN_SLLV: dec_p0.alu_ctrl = ALU_SLLV;
                            FN_SRLV: dec_p0.alu_ctrl = ALU_SRLV;
                            default: dec_p0.alu_ctrl = ALU_SRAV;
                        endcase
                    end
                    default: legal_p0 = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                dec_p0.alu_ctrl  = ALU_ADD;
                dec_p0.in1       = id_rs_data;
                dec_p0.in2       = imm_sext_p0;
                dec_p0.rd        = rt_p0;
                dec_p0.reg_write = 1'b1;
            end
            OP_SLTI: begin
                dec_p0.alu_ctrl  = ALU_LESS;
                dec_p0.in1       = id_rs_data;
                dec_p0.in2       = imm_sext_p0;
                dec_p0.rd        = rt_p0;
                dec_p0.reg_write = 1'b1;
            end
            OP_ANDI: begin
                dec_p0.alu_ctrl  = ALU_AND;
                dec_p0.in1       = id_rs_data;
                dec_p0.in2       = imm_zext_p0;
                dec_p0.rd        = rt_p0;
                dec_p0.reg_write = 1'b1;
            end
            OP_ORI: begin
                dec_p0.alu_ctrl  = ALU_OR;
                dec_p0.in1       = id_rs_data;
                dec_p0.in2       = imm_zext_p0;
                dec_p0.rd        = rt_p0;
                dec_p0.reg_write = 1'b1;
            end
            OP_LUI: begin
                // The ALU builds imm<<16 with its left shifter; rs is not read.
                uses_rs_p0       = 1'b0;
                dec_p0.alu_ctrl  = ALU_SLL;
                dec_p0.in1       = imm_zext_p0;
                dec_p0.shamt     = 5'd16;
                dec_p0.rd        = rt_p0;
                dec_p0.reg_write = 1'b1;
            end
            OP_LW: begin
                dec_p0.alu_ctrl  = ALU_ADD;
                dec_p0.in1       = id_rs_data;
                dec_p0.in2       = imm_sext_p0;
                dec_p0.rd        = rt_p0;
                dec_p0.reg_write = 1'b1;
                dec_p0.mem_read  = 1'b1;
            end
            OP_SW: begin
                uses_rt_p0        = 1'b1;
                dec_p0.alu_ctrl   = ALU_ADD;
                dec_p0.in1        = id_rs_data;
                dec_p0.in2        = imm_sext_p0;
                dec_p0.mem_write  = 1'b1;
                dec_p0.store_data = id_rt_data;
            end
            OP_BEQ, OP_BNE: begin
                // Branch compare is done by subtraction in EX; nothing is written back.
                uses_rt_p0      = 1'b1;
                dec_p0.alu_ctrl = ALU_SUB;
                dec_p0.in1      = id_rs_data;
                dec_p0.in2      = id_rt_data;
            end
            default: legal_p0 = 1'b0;
        endcase

        // Unsupported encodings still occupy a slot but carry no work.
        if (!legal_p0) begin
            dec_p0         = '0;
            dec_p0.illegal = 1'b1;
        end

        // Writes to $0 are discarded.
        if (dec_p0.rd == '0) begin
            dec_p0.reg_write = 1'b0;
        end
    end

    payload_t pay_p1;
    logic     vld_p1;

    // A load in EX cannot forward in time for an instruction that reads its result.
    assign hazard_p0 = vld_p1 && pay_p1.mem_read && (pay_p1.rd != '0) &&
                       ((uses_rs_p0 && (rs_p0 == pay_p1.rd)) ||
                        (uses_rt_p0 && (rt_p0 == pay_p1.rd)));

    assign id_ready  = !flush && !hazard_p0 && (!vld_p1 || ex_ready);
    assign accept_p0 = id_valid && id_ready;

    // ---------------------------------------------------------------
    // p1: ID/EX pipeline register
    // ---------------------------------------------------------------
    // Load a new payload, hold it during a stall, or drop to a cleared bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            pay_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            pay_p1 <= '0;
        end else if (vld_p1 && !ex_ready) begin
            vld_p1 <= vld_p1;
            pay_p1 <= pay_p1;
        end else begin
            vld_p1 <= accept_p0;
            pay_p1 <= accept_p0 ? dec_p0 : '0;
        end
    end

    assign ex_valid      = vld_p1;
    assign ex_alu_ctrl   = pay_p1.alu_ctrl;
    assign ex_in1        = pay_p1.in1;
    assign ex_in2        = pay_p1.in2;
    assign ex_shamt      = pay_p1.shamt;
    assign ex_rd         = pay_p1.rd;
    assign ex_reg_write  = pay_p1.reg_write;
    assign ex_mem_read   = pay_p1.mem_read;
    assign ex_mem_write  = pay_p1.mem_write;
    assign ex_store_data = pay_p1.store_data;
    assign ex_illegal    = pay_p1.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a spec-level model of the EX slot is
// compared against the DUT every cycle, and hand-computed literals pin the
// key scenarios (decode, load-use bubble, stall/flush, reset, illegal, sw).
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [3:0]  ex_alu_ctrl;
    logic [31:0] ex_in1;
    logic [31:0] ex_in2;
    logic [4:0]  ex_shamt;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [31:0] ex_store_data;
    logic        ex_illegal;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_instr     (id_instr),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .flush        (flush),
        .ex_ready     (ex_ready),
        .ex_valid     (ex_valid),
        .ex_alu_ctrl  (ex_alu_ctrl),
        .ex_in1       (ex_in1),
        .ex_in2       (ex_in2),
        .ex_shamt     (ex_shamt),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_store_data(ex_store_data),
        .ex_illegal   (ex_illegal)
    );

    typedef struct packed {
        logic        valid;
        logic [3:0]  alu;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  shamt;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] sd;
        logic        ill;
    } slot_t;

    slot_t exp_slot = '0;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // What EX must receive for one accepted instruction with operands a (rs) and b (rt).
    function automatic slot_t model_decode(input logic [31:0] instr, input logic [31:0] a,
                                           input logic [31:0] b);
        slot_t       s;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] sx;
        logic [31:0] zx;
        op = instr[31:26];
        fn = instr[5:0];
        sx = {{16{instr[15]}}, instr[15:0]};
        zx = {16'h0000, instr[15:0]};
        s  = '0;
        s.valid = 1'b1;
        if (op == 6'h00) begin
            s.rd = instr[15:11];
            s.rw = 1'b1;
            s.in1 = a;
            s.in2 = b;
            case (fn)
                6'h20, 6'h21: s.alu = 4'd1;
                6'h22, 6'h23: s.alu = 4'd4;
                6'h24: s.alu = 4'd2;
                6'h25: s.alu = 4'd3;
                6'h27: s.alu = 4'd9;
                6'h2A: s.alu = 4'd8;
                6'h00: begin s.alu = 4'd5; s.in1 = b; s.in2 = 0; s.shamt = instr[10:6]; end
                6'h02: begin s.alu = 4'd6; s.in1 = b; s.in2 = 0; s.shamt = instr[10:6]; end
                6'h03: begin s.alu = 4'd7; s.in1 = b; s.in2 = 0; s.shamt = instr[10:6]; end
                6'h04: begin s.alu = 4'd10; s.in1 = b; s.in2 = a % 32; end
                6'h06: begin s.alu = 4'd11; s.in1 = b; s.in2 = a % 32; end
                6'h07: begin s.alu = 4'd12; s.in1 = b; s.in2 = a % 32; end
                default: s.ill = 1'b1;
            endcase
        end else begin
            s.rd = instr[20:16];
            s.rw = 1'b1;
            s.in1 = a;
            case (op)
                6'h08, 6'h09: begin s.alu = 4'd1; s.in2 = sx; end
                6'h0A: begin s.alu = 4'd8; s.in2 = sx; end
                6'h0C: begin s.alu = 4'd2; s.in2 = zx; end
                6'h0D: begin s.alu = 4'd3; s.in2 = zx; end
                6'h0F: begin s.alu = 4'd5; s.in1 = zx; s.shamt = 5'd16; end
                6'h23: begin s.alu = 4'd1; s.in2 = sx; s.mr = 1'b1; end
                6'h2B: begin s.alu = 4'd1; s.in2 = sx; s.mw = 1'b1; s.sd = b; s.rd = 0; s.rw = 0; end
                6'h04, 6'h05: begin s.alu = 4'd4; s.in2 = b; s.rd = 0; s.rw = 0; end
                default: s.ill = 1'b1;
            endcase
        end
        if (s.ill) begin
            s       = '0;
            s.valid = 1'b1;
            s.ill   = 1'b1;
        end
        if (s.rd == 0) s.rw = 1'b0;
        return s;
    endfunction

    // Whether the stage may take instr given what currently sits in EX.
    function automatic logic model_ready(input logic [31:0] instr, input logic fl,
                                         input logic er, input slot_t cur);
        logic [5:0] op;
        logic [5:0] fn;
        logic       urs;
        logic       urt;
        logic       haz;
        op  = instr[31:26];
        fn  = instr[5:0];
        urs = !((op == 6'h00 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) || op == 6'h0F);
        urt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
        haz = cur.valid && cur.mr && (cur.rd != 0) &&
              ((urs && instr[25:21] == cur.rd) || (urt && instr[20:16] == cur.rd));
        return !fl && !haz && (!cur.valid || er);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, want, $time);
        end
    endtask

    // Model of the EX slot, advanced on the same events as the DUT.
    always @(posedge clk or posedge reset) begin
        if (reset) exp_slot = '0;
        else if (flush) exp_slot = '0;
        else if (exp_slot.valid && !ex_ready) exp_slot = exp_slot;
        else if (id_valid && model_ready(id_instr, flush, ex_ready, exp_slot))
            exp_slot = model_decode(id_instr, id_rs_data, id_rt_data);
        else exp_slot = '0;
    end

    // Per-cycle comparison, well away from the rising edge.
    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            chk("m_valid", 32'(ex_valid), 32'(exp_slot.valid));
            chk("m_alu", 32'(ex_alu_ctrl), 32'(exp_slot.alu));
            chk("m_in1", ex_in1, exp_slot.in1);
            chk("m_in2", ex_in2, exp_slot.in2);
            chk("m_shamt", 32'(ex_shamt), 32'(exp_slot.shamt));
            chk("m_rd", 32'(ex_rd), 32'(exp_slot.rd));
            chk("m_rw", 32'(ex_reg_write), 32'(exp_slot.rw));
            chk("m_mr", 32'(ex_mem_read), 32'(exp_slot.mr));
            chk("m_mw", 32'(ex_mem_write), 32'(exp_slot.mw));
            chk("m_sd", ex_store_data, exp_slot.sd);
            chk("m_ill", 32'(ex_illegal), 32'(exp_slot.ill));
            chk("m_ready", 32'(id_ready), 32'(model_ready(id_instr, flush, ex_ready, exp_slot)));
        end
    end

    task automatic drive(input logic [31:0] instr, input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic v, input logic fl, input logic er);
        @(negedge clk);
        id_instr   = instr;
        id_rs_data = rsd;
        id_rt_data = rtd;
        id_valid   = v;
        flush      = fl;
        ex_ready   = er;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sweep [20];

    initial begin
        reset      = 1'b1;
        id_valid   = 1'b0;
        id_instr   = '0;
        id_rs_data = '0;
        id_rt_data = '0;
        flush      = 1'b0;
        ex_ready   = 1'b1;
        chk_en     = 1'b1;
        #1;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_alu", 32'(ex_alu_ctrl), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // add $3,$1,$2 then sra $4,$2,3
        drive(rtype(1, 2, 3, 0, 6'h20), 32'd5, 32'd7, 1, 0, 1);
        after_edge();
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_alu", 32'(ex_alu_ctrl), 32'd1);
        chk("add_in1", ex_in1, 32'd5);
        chk("add_in2", ex_in2, 32'd7);
        chk("add_rd", 32'(ex_rd), 32'd3);
        chk("add_rw", 32'(ex_reg_write), 32'd1);
        drive(rtype(0, 2, 4, 3, 6'h03), 32'd0, 32'h8000_0000, 1, 0, 1);
        after_edge();
        chk("sra_alu", 32'(ex_alu_ctrl), 32'd7);
        chk("sra_in1", ex_in1, 32'h8000_0000);
        chk("sra_shamt", 32'(ex_shamt), 32'd3);

        // Asynchronous reset while a valid payload sits in EX
        drive(rtype(1, 2, 3, 0, 6'h20), 32'd5, 32'd7, 1, 0, 1);
        after_edge();
        chk("pre_rst_valid", 32'(ex_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(ex_valid), 32'd0);
        chk("arst_alu", 32'(ex_alu_ctrl), 32'd0);
        chk("arst_in1", ex_in1, 32'd0);
        chk("arst_rd", 32'(ex_rd), 32'd0);
        drive(rtype(1, 2, 3, 0, 6'h20), 32'd5, 32'd7, 1, 0, 1);
        reset = 1'b0;
        after_edge();
        chk("post_rst_valid", 32'(ex_valid), 32'd1);
        chk("post_rst_alu", 32'(ex_alu_ctrl), 32'd1);
        chk("post_rst_rd", 32'(ex_rd), 32'd3);

        // Immediates
        drive(itype(6'h0F, 0, 4, 16'h1234), 32'hAAAA, 32'hBBBB, 1, 0, 1);
        after_edge();
        chk("lui_alu", 32'(ex_alu_ctrl), 32'd5);
        chk("lui_in1", ex_in1, 32'h0000_1234);
        chk("lui_shamt", 32'(ex_shamt), 32'd16);
        drive(itype(6'h0C, 1, 5, 16'hFFFF), 32'h1234_5678, 32'd0, 1, 0, 1);
        after_edge();
        chk("andi_in2", ex_in2, 32'h0000_FFFF);
        drive(itype(6'h08, 1, 5, 16'hFFFF), 32'd3, 32'd0, 1, 0, 1);
        after_edge();
        chk("addi_in2", ex_in2, 32'hFFFF_FFFF);

        // lw $2,4($1) then dependent add $5,$2,$1: one bubble
        drive(itype(6'h23, 1, 2, 16'd4), 32'd100, 32'd0, 1, 0, 1);
        after_edge();
        chk("lw_mr", 32'(ex_mem_read), 32'd1);
        chk("lw_rd", 32'(ex_rd), 32'd2);
        drive(rtype(2, 1, 5, 0, 6'h20), 32'd9, 32'd100, 1, 0, 1);
        #2;
        chk("luse_ready0", 32'(id_ready), 32'd0);
        after_edge();
        chk("bubble_valid", 32'(ex_valid), 32'd0);
        chk("bubble_alu", 32'(ex_alu_ctrl), 32'd0);
        chk("luse_ready1", 32'(id_ready), 32'd1);
        after_edge();
        chk("dep_valid", 32'(ex_valid), 32'd1);
        chk("dep_in1", ex_in1, 32'd9);
        chk("dep_rd", 32'(ex_rd), 32'd5);

        // lw then independent add $5,$1,$0: no bubble
        drive(itype(6'h23, 1, 2, 16'd4), 32'd100, 32'd0, 1, 0, 1);
        after_edge();
        drive(rtype(1, 0, 5, 0, 6'h20), 32'd100, 32'd0, 1, 0, 1);
        #2;
        chk("indep_ready", 32'(id_ready), 32'd1);
        after_edge();
        chk("indep_valid", 32'(ex_valid), 32'd1);
        chk("indep_alu", 32'(ex_alu_ctrl), 32'd1);

        // Stall with a valid payload, flush on the second stalled cycle
        drive(rtype(1, 2, 7, 0, 6'h22), 32'd20, 32'd8, 1, 0, 1);
        after_edge();
        chk("sub_alu", 32'(ex_alu_ctrl), 32'd4);
        drive(rtype(3, 4, 9, 0, 6'h25), 32'd1, 32'd2, 1, 0, 0);
        #2;
        chk("stall_ready", 32'(id_ready), 32'd0);
        after_edge();
        chk("hold_valid", 32'(ex_valid), 32'd1);
        chk("hold_alu", 32'(ex_alu_ctrl), 32'd4);
        chk("hold_in1", ex_in1, 32'd20);
        chk("hold_rd", 32'(ex_rd), 32'd7);
        drive(rtype(3, 4, 9, 0, 6'h25), 32'd1, 32'd2, 1, 1, 0);
        #2;
        chk("flush_ready", 32'(id_ready), 32'd0);
        after_edge();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_alu", 32'(ex_alu_ctrl), 32'd0);
        drive(32'd0, 32'd0, 32'd0, 0, 0, 0);
        after_edge();
        chk("idle_valid", 32'(ex_valid), 32'd0);

        // Unsupported opcode and a store
        drive(itype(6'h3F, 1, 2, 16'h0055), 32'd1, 32'd2, 1, 0, 1);
        after_edge();
        chk("ill_valid", 32'(ex_valid), 32'd1);
        chk("ill_flag", 32'(ex_illegal), 32'd1);
        chk("ill_alu", 32'(ex_alu_ctrl), 32'd0);
        chk("ill_rw", 32'(ex_reg_write), 32'd0);
        drive(itype(6'h2B, 1, 6, 16'd0), 32'd10, 32'h0000_DEAD, 1, 0, 1);
        after_edge();
        chk("sw_mw", 32'(ex_mem_write), 32'd1);
        chk("sw_sd", ex_store_data, 32'h0000_DEAD);
        chk("sw_rw", 32'(ex_reg_write), 32'd0);
        chk("sw_rd", 32'(ex_rd), 32'd0);

        // Remaining encodings, hazard corners and stalls, checked by the model
        sweep = '{rtype(1, 2, 3, 0, 6'h23), rtype(1, 2, 3, 0, 6'h24), rtype(1, 2, 3, 0, 6'h27),
                  rtype(1, 2, 3, 0, 6'h2A), rtype(0, 2, 3, 7, 6'h00), rtype(0, 2, 3, 9, 6'h02),
                  rtype(1, 2, 3, 0, 6'h04), rtype(1, 2, 3, 0, 6'h06), rtype(1, 2, 3, 0, 6'h07),
                  itype(6'h0A, 1, 4, 16'h8001), itype(6'h0D, 1, 4, 16'h8001), itype(6'h04, 1, 2, 16'd3),
                  itype(6'h05, 1, 2, 16'd3), rtype(1, 2, 3, 0, 6'h3F), itype(6'h0F, 0, 0, 16'h00FF),
                  itype(6'h23, 9, 8, 16'hFFFC), itype(6'h2B, 9, 8, 16'd0), itype(6'h2B, 9, 8, 16'd0),
                  itype(6'h23, 9, 8, 16'd8), rtype(8, 11, 10, 2, 6'h00)};
        for (int i = 0; i < 20; i++) begin
            drive(sweep[i], 32'h1357_9BDF + 32'(i * 37), 32'hF0E1_D2C3 ^ 32'(i), 1, 0,
                  (i % 7) != 5);
        end
        drive(32'd0, 32'd0, 32'd0, 0, 0, 1);
        after_edge();
        after_edge();
        @(negedge clk);
        #2;
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-and-issue pipeline stage that drives the 32-bit ALU. It turns a fetched MIPS instruction plus its register-file read data into ALU control code, operands and shift amount, and registers them into the ID/EX pipeline register. The stage applies a valid/ready handshake toward EX, holds on downstream stall, inserts bubbles on flush and on load-use hazards, and flags unsupported instructions.

## Interface
- No parameters. Data width is fixed at 32 bits; register index width is fixed at 5 bits.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all registered state.
- id_valid  in  1  instruction on id_instr is valid.
- id_ready  out  1  the stage accepts id_instr this cycle (combinational).
- id_instr  in  32  MIPS instruction word.
- id_rs_data  in  32  register-file value of the instruction's rs field.
- id_rt_data  in  32  register-file value of the instruction's rt field.
- flush  in  1  kill the EX-stage contents and block acceptance this cycle.
- ex_ready  in  1  EX consumes the current payload this cycle.
- ex_valid  out  1  payload is valid.
- ex_alu_ctrl  out  4  codes: ADD=1, AND=2, OR=3, SUB=4, SLL=5, SRL=6, SRA=7, LESS=8, NOR=9, SLLV=10, SRLV=11, SRAV=12; 0 = none/bubble.
- ex_in1, ex_in2  out  32  ALU operands.
- ex_shamt  out  5  shift amount for SLL/SRL/SRA.
- ex_rd  out  5  destination register; 0 when there is no write.
- ex_reg_write  out  1  result is written back.
- ex_mem_read  out  1  the instruction is a load (lw).
- ex_mem_write  out  1  the instruction is a store (sw).
- ex_store_data  out  32  rt data for sw; 0 otherwise.
- ex_illegal  out  1  unsupported opcode or funct.

## Operation
- R-type (op=0x00), decoded from funct:
  - add/addu 0x20/0x21 → ADD
  - sub/subu 0x22/0x23 → SUB
  - and 0x24 → AND
  - or 0x25 → OR
  - nor 0x27 → NOR
  - slt 0x2A → LESS
  - For all of the above: in1=rs data, in2=rt data.
- R-type shifts:
  - sll 0x00 / srl 0x02 / sra 0x03 → in1=rt data, shamt=instr[10:6], in2=0.
  - sllv 0x04 / srlv 0x06 / srav 0x07 → in1=rt data, in2={27'b0, rs data[4:0]}.
- All R-type: ex_rd=instr[15:11], reg_write=1.
- I-type immediates; ex_rd=rt, reg_write=1 unless noted:
  - addi/addiu 0x08/0x09 → ADD, in2=sign-extended imm.
  - slti 0x0A → LESS, in2=sign-extended imm.
  - andi 0x0C → AND, in2=zero-extended imm.
  - ori 0x0D → OR, in2=zero-extended imm.
  - lui 0x0F → SLL, in1={16'b0, imm}, shamt=16.
  - lw 0x23 → ADD, in1=rs data, in2=sign-extended imm, mem_read=1.
  - sw 0x2B → ADD, same operands, mem_write=1, store_data=rt data, ex_rd=0, reg_write=0.
  - beq/bne 0x04/0x05 → SUB, in1=rs data, in2=rt data, ex_rd=0, reg_write=0.
- Any other op or funct: ex_illegal=1, alu_ctrl=0, every data output 0, reg_write=0, mem flags 0. The instruction still occupies a valid slot.
- Any decoded ex_rd of 0 forces reg_write=0.
- Source usage:
  - uses_rs is false for sll/srl/sra/lui; true otherwise.
  - uses_rt is true for R-type, sw, beq and bne.
- Load-use hazard: hazard = ex_valid & ex_mem_read & (ex_rd≠0) & ((uses_rs & rs==ex_rd) | (uses_rt & rt==ex_rd)).
- id_ready = ~flush & ~hazard & (~ex_valid | ex_ready).
- accept = id_valid & id_ready.
- Register update, in priority order:
  1. reset → ex_valid and every ex_* output = 0.
  2. flush → ex_valid=0; payload is don't-care but is cleared to 0.
  3. ex_valid & ~ex_ready → hold all outputs.
  4. Otherwise → ex_valid=accept. The payload loads when accept; it is cleared to 0 when no instruction is accepted (bubble).

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the ex_* outputs after edge N.
- Throughput is 1 instruction per cycle when there is no stall or hazard.
- A load-use hazard costs exactly one bubble: the dependent instruction is held (id_ready=0) while the lw sits in EX, and is accepted on the cycle after the lw leaves.
- Stall (ex_valid & ~ex_ready): all ex_* outputs hold bit-exact for any number of cycles.
- Flush during a stall: the flush wins, and ex_valid=0 after the next edge.
- Reset asserted mid-stream: outputs go to 0 immediately (asynchronous). The first accept is possible on the first edge after deassertion.
- id_ready depends combinationally on flush, ex_ready and the incoming instruction fields.

## Test plan
- Reset mid-stream with ex_valid=1 → all outputs 0 without waiting for a clock edge; after release, add $3,$1,$2 is accepted on the next edge.
- add $3,$1,$2 with rs=5, rt=7 → next cycle alu_ctrl=1, in1=5, in2=7, ex_rd=3, reg_write=1. Then sra $4,$2,3 with rt=0x80000000 → alu_ctrl=7, in1=0x80000000, shamt=3.
- Immediates:
  - lui $4,0x1234 → alu_ctrl=5, in1=0x00001234, shamt=16.
  - andi imm 0xFFFF → in2=0x0000FFFF.
  - addi imm 0xFFFF → in2=0xFFFFFFFF.
- lw $2,4($1) followed by add $5,$2,$1:
  - id_ready=0 for exactly one cycle and one bubble appears (ex_valid=0, alu_ctrl=0).
  - The add then issues.
  - Repeat with add $5,$1,$0 → no bubble.
- ex_ready=0 for 3 cycles with a valid payload → outputs are stable and id_ready=0. Assert flush on the 2nd cycle → ex_valid=0 after that edge.
- op=0x3F → ex_valid=1, ex_illegal=1, alu_ctrl=0, reg_write=0. Also sw $6,0($1) → mem_write=1, store_data=rt data, reg_write=0, ex_rd=0.
